// File: rtl/issue_pkg.sv
// issue_pkg: shared types and constants for the scoreboard issue unit
package issue_pkg;
  typedef enum logic [1:0] {FU_ALU = 2'd0, FU_MEM = 2'd1, FU_MULDIV = 2'd2, FU_BR = 2'd3} fu_class_e;
  localparam logic BUBBLE_FILL = 1'b0;
  function automatic int reg_aw(input int nregs);
    return $clog2(nregs);
  endfunction
endpackage

// File: rtl/issue_busy_table.sv
// issue_busy_table: per-register busy bits, set-over-clear, x0 never busy
module issue_busy_table import issue_pkg::*; #(
  parameter int NREGS = 32,
  parameter int AW = reg_aw(NREGS)
)(
  input  logic             clk,
  input  logic             nrst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_rd,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_rd,
  output logic [NREGS-1:0] busy_eff
);
  logic [NREGS-1:0] busy, set_mask, clr_mask;
  always_comb begin
    set_mask = set_en ? (NREGS'(1) << set_rd) & ~NREGS'(1) : '0;
    clr_mask = clr_en ? NREGS'(1) << clr_rd : '0;
    busy_eff = busy & ~clr_mask;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) busy <= '0;
    else busy <= busy_eff | set_mask;
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: scoreboard issue stage with handshake, kill window and MULDIV hazard
module issue_scoreboard import issue_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int PAYLOAD_W = 128,
  parameter int KILL_DEPTH = 2,
  parameter int PERF_W = 16
)(
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic                     in_rs1_used,
  input  logic                     in_rs2_used,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic                     in_we,
  input  logic [1:0]               in_fu,
  input  logic [PAYLOAD_W-1:0]     in_payload,
  output logic                     out_valid,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic                     out_we,
  output logic [1:0]               out_fu,
  output logic [PAYLOAD_W-1:0]     out_payload,
  input  logic                     wb_we,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic                     md_done,
  input  logic                     bjtaken,
  output logic                     stall,
  output logic                     kill,
  output logic [PERF_W-1:0]        stall_cnt
);
  localparam int AW = reg_aw(NREGS);
  localparam int KW = $clog2(KILL_DEPTH) + 1;
  if (KILL_DEPTH < 1 || XLEN < 1) begin : g_bad_cfg
    $error("issue_scoreboard: KILL_DEPTH and XLEN must be >= 1");
  end
  logic [NREGS-1:0] busy_eff;
  logic [KW-1:0] kill_cnt;
  logic md_busy, raw, waw, struct_haz, fire;
  issue_busy_table #(.NREGS(NREGS), .AW(AW)) u_busy (
    .clk, .nrst,
    .set_en(fire && in_we), .set_rd(in_rd),
    .clr_en(wb_we), .clr_rd(wb_rd),
    .busy_eff
  );
  always_comb begin
    raw = (in_rs1_used && in_rs1 != '0 && busy_eff[in_rs1]) ||
          (in_rs2_used && in_rs2 != '0 && busy_eff[in_rs2]);
    waw = in_we && in_rd != '0 && busy_eff[in_rd];
    struct_haz = in_fu == FU_MULDIV && md_busy && !md_done;
    kill = bjtaken || kill_cnt != '0;
    stall = in_valid && !kill && (raw || waw || struct_haz);
    in_ready = kill || !stall;
    fire = in_valid && in_ready && !kill;
  end
  // a non-firing cycle loads a bubble so execute never sees stale fields
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      md_busy <= 1'b0;
      kill_cnt <= '0;
      stall_cnt <= '0;
      out_valid <= 1'b0;
      out_rd <= '0;
      out_we <= 1'b0;
      out_fu <= FU_ALU;
      out_payload <= {PAYLOAD_W{BUBBLE_FILL}};
    end else begin
      md_busy <= (fire && in_fu == FU_MULDIV) || (md_busy && !md_done);
      kill_cnt <= bjtaken ? KW'(KILL_DEPTH - 1) : kill_cnt - KW'(kill_cnt != '0);
      stall_cnt <= stall_cnt + PERF_W'(stall && !(&stall_cnt));
      out_valid <= fire;
      out_rd <= fire ? in_rd : '0;
      out_we <= fire && in_we;
      out_fu <= fire ? in_fu : FU_ALU;
      out_payload <= fire ? in_payload : {PAYLOAD_W{BUBBLE_FILL}};
    end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Parametrised scoreboard-based issue unit. It sits between decode and execute and replaces the fixed 2-bubble kill and the single stall flag with a per-register busy table. It adds a valid/ready handshake, a configurable branch-kill window, a single-outstanding MULDIV structural hazard, and a saturating stall-cycle counter. Operand values are not handled here: the regfile stays outside, and the issued payload is an opaque bus registered into the execute pipe.

Parameters:
XLEN, 32, architectural register width; informational only, used for payload sizing by the instantiator
NREGS, 32, number of architectural registers; x0 is hardwired non-busy
PAYLOAD_W, 128, width of the opaque decoded-instruction bus passed to execute
KILL_DEPTH, 2, number of cycles, starting with the bjtaken cycle, during which consumed instructions are dropped; must be >= 1
PERF_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
in_valid  in  1  decode presents an instruction
in_ready  out  1  issue accepts the instruction this cycle
in_rs1, in_rs2  in  $clog2(NREGS)  source register addresses
in_rs1_used, in_rs2_used  in  1  source is actually read
in_rd  in  $clog2(NREGS)  destination address
in_we  in  1  instruction writes rd
in_fu  in  2  functional-unit class, fu_class_e
in_payload  in  PAYLOAD_W  decoded fields for execute
out_valid  out  1  execute-stage register holds a live instruction
out_rd  out  $clog2(NREGS)  registered rd
out_we  out  1  registered we
out_fu  out  2  registered FU class
out_payload  out  PAYLOAD_W  registered payload
wb_we  in  1  commit writeback strobe
wb_rd  in  $clog2(NREGS)  commit writeback address
md_done  in  1  MULDIV unit finished its operation
bjtaken  in  1  branch or jump resolved taken in execute
stall  out  1  hazard blocks the instruction presented this cycle
kill  out  1  kill window active this cycle
stall_cnt  out  PERF_W  saturating count of stall cycles

Behaviour:
- Reset: busy[*]=0, md_busy=0, kill_cnt=0, out_valid=0, out_rd=0, out_we=0, out_fu=FU_ALU, out_payload=0, stall_cnt=0. Reset mid-operation discards all state immediately.
- busy_eff = busy & ~(wb_we ? onehot(wb_rd) : 0). Same-cycle writeback resolves the hazard; the regfile is write-first.
- RAW: in_rsX_used, rsX != 0 and busy_eff[rsX].
- WAW: in_we, rd != 0 and busy_eff[rd].
- STRUCT: in_fu == FU_MULDIV and md_busy and !md_done.
- kill = bjtaken or (kill_cnt != 0).
- stall = in_valid and !kill and (RAW or WAW or STRUCT).
- in_ready = kill or !stall. Killed instructions are consumed and dropped.
- fire = in_valid and in_ready and !kill.
- Output register, 1-cycle latency: on fire it loads in_* and sets out_valid=1. Otherwise it loads a bubble: out_valid=0, out_we=0, out_rd=0, out_fu=FU_ALU, payload=0.
- Busy set on fire when in_we and rd != 0. Busy clear on wb_we. If set and clear hit the same register in the same cycle, set wins.
- md_busy is set on fire with FU_MULDIV and cleared on md_done. If both happen in the same cycle, the set wins.
- Kill counter: on bjtaken, kill_cnt <= KILL_DEPTH-1 (restart if already counting). Otherwise it decrements while nonzero. The instruction firing in the bjtaken cycle is suppressed.
- bjtaken does not clear busy bits, because no younger instruction has issued.
- stall_cnt increments on each stall cycle and saturates at all-ones.
- busy[0] is never set.

Decomposition:
- Shared package issue_pkg:
  - fu_class_e: FU_ALU=0, FU_MEM=1, FU_MULDIV=2, FU_BR=3
  - REG_AW = $clog2(NREGS) helper
  - bubble payload constant
- One sub-module, issue_busy_table. It holds the NREGS busy bits with the set/clear priority and x0 masking, and exposes the combinational busy_eff vector.

Test Plan:
- Issue "x5 <= ..." (we=1, rd=5), then present rs1=5 with no writeback -> stall=1, in_ready=0, stall_cnt increments each cycle. Assert wb_we=1, wb_rd=5 -> same cycle stall=0, fire; out_valid=1 the next cycle.
- WAW, rd=7 busy, new in_rd=7 -> stall. Writeback of x7 and new issue in the same cycle -> busy[7] remains 1.
- rs1=0, rd=0 with busy state arbitrary -> never stalls; busy[0] stays 0.
- KILL_DEPTH=3: bjtaken at cycle t with in_valid=1 at t..t+3 -> instructions at t, t+1 and t+2 are consumed with out_valid=0 at t+1..t+3. The instruction at t+3 fires, out_valid=1 at t+4. A second bjtaken at t+1 extends the window through t+3.
- MULDIV issued, second MULDIV presented -> stall until md_done. With md_done and the second MULDIV in the same cycle -> fire, md_busy stays 1.
- Reset asserted while busy[3]=1, kill_cnt=1 and out_valid=1 -> all outputs return to reset values asynchronously; the first post-reset instruction reading x3 fires without stall.
